hazard_controller: RTL and testbench

Pipeline hazard unit for the five-stage MIPS datapath. Consumes the decoded control bundle (MemRead, RegWrite, Branch, Jump, write-register indices) from the ID/EX and EX/MEM pipeline registers plus the raw instruction fields in IF/ID. Produces the PC/stage write enables, bubble inserts and IF/ID flush that the datapath controller does not generate. Handles load-use stalls, branch-operand stalls (branches resolve in ID), taken-branch/jump flushes and multi-cycle multiply freezes.

---
 rtl/hazard_controller_if.sv | 32 +++
 rtl/hazard_controller.sv | 69 ++++++
 tb/tb_hazard_controller.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: decoded pipeline fields in, stall/bubble/flush controls out
interface hazard_controller_if;
  logic [5:0] IFID_OpCode;
  logic [4:0] IFID_Rs;
  logic [4:0] IFID_Rt;
  logic ID_Branch;
  logic ID_Jump;
  logic ID_BranchTaken;
  logic IDEX_MemRead;
  logic IDEX_RegWrite;
  logic [4:0] IDEX_WriteReg;
  logic IDEX_Mul;
  logic EXMEM_MemRead;
  logic [4:0] EXMEM_WriteReg;
  logic PCWrite;
  logic IFID_WriteEnable;
  logic IFID_Flush;
  logic IDEX_Bubble;
  logic EXMEM_Bubble;
  logic [2:0] StageWriteEnable;
  logic [15:0] StallCount;
  modport master (
    output IFID_OpCode, IFID_Rs, IFID_Rt, ID_Branch, ID_Jump, ID_BranchTaken,
           IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg, IDEX_Mul, EXMEM_MemRead, EXMEM_WriteReg,
    input  PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, StageWriteEnable, StallCount
  );
  modport slave (
    input  IFID_OpCode, IFID_Rs, IFID_Rt, ID_Branch, ID_Jump, ID_BranchTaken,
           IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg, IDEX_Mul, EXMEM_MemRead, EXMEM_WriteReg,
    output PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, StageWriteEnable, StallCount
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: MIPS load-use/branch stalls, flushes; define HAZARD_MUL_STALL_EN for multiply freeze
module hazard_controller #(
  parameter int MUL_CYCLES = 4
) (
  input logic Clock,
  input logic Reset,
  hazard_controller_if.slave hz
);
  logic uses_rs, uses_rt, rs_ok, rt_ok, hit_idex, hit_exmem, stall, flush;
  logic in_mul, enter, run_stall, run_flush, go;
  logic [15:0] stall_cnt;
  assign uses_rs = !(hz.IFID_OpCode inside {6'b000010, 6'b000011, 6'b001111});
  assign uses_rt = hz.IFID_OpCode inside {6'b000000, 6'b000100, 6'b000101, 6'b011100,
                                          6'b011111, 6'b101000, 6'b101001, 6'b101011};
  assign rs_ok = uses_rs && hz.IFID_Rs != 5'd0;
  assign rt_ok = uses_rt && hz.IFID_Rt != 5'd0;
  assign hit_idex = (rs_ok && hz.IFID_Rs == hz.IDEX_WriteReg) || (rt_ok && hz.IFID_Rt == hz.IDEX_WriteReg);
  assign hit_exmem = (rs_ok && hz.IFID_Rs == hz.EXMEM_WriteReg) || (rt_ok && hz.IFID_Rt == hz.EXMEM_WriteReg);
  assign stall = (hz.IDEX_MemRead && hit_idex) ||
                 (hz.ID_Branch && ((hz.IDEX_RegWrite && hit_idex) || (hz.EXMEM_MemRead && hit_exmem)));
  assign flush = hz.ID_Jump || (hz.ID_Branch && hz.ID_BranchTaken);
`ifdef HAZARD_MUL_STALL_EN
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MUL = 1'b1;
  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  logic [0:0] state;
  logic [CW-1:0] mul_cnt;
  logic mul_ack;
  assign in_mul = state == MUL;
  assign enter = !in_mul && hz.IDEX_Mul && !mul_ack;
  // mul_ack lives for exactly the one RUN cycle after the freeze so the held multiply is not re-entered
  always_ff @(posedge Clock)
    if (Reset) begin
      state <= RUN;
      mul_cnt <= '0;
      mul_ack <= 1'b0;
    end else if (!in_mul) begin
      mul_ack <= 1'b0;
      if (enter) begin
        state <= MUL;
        mul_cnt <= CW'(MUL_CYCLES - 2);
      end
    end else begin
      mul_cnt <= mul_cnt - CW'(1);
      if (mul_cnt == '0) begin
        state <= RUN;
        mul_ack <= 1'b1;
      end
    end
`else
  logic unused_mul;
  assign unused_mul = hz.IDEX_Mul & (MUL_CYCLES > 1);
  assign in_mul = 1'b0;
  assign enter = 1'b0;
`endif
  assign run_stall = !in_mul && !enter && stall;
  assign run_flush = !in_mul && !enter && !stall && flush;
  assign go = !Reset && !in_mul && !run_stall;
  assign hz.PCWrite = go;
  assign hz.IFID_WriteEnable = go;
  assign hz.IFID_Flush = Reset || run_flush;
  assign hz.IDEX_Bubble = Reset || run_stall;
  assign hz.EXMEM_Bubble = Reset || in_mul;
  assign hz.StageWriteEnable = Reset ? 3'b000 : in_mul ? 3'b110 : 3'b111;
  assign hz.StallCount = stall_cnt;
  always_ff @(posedge Clock)
    if (Reset) stall_cnt <= '0;
    else if (!go && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed hazard scenarios plus randomized checks against a cycle-count model
module tb_hazard_controller;
  logic Clock, Reset;
  int checks = 0;
  int failures = 0;
  hazard_controller_if hz();
  hazard_controller #(.MUL_CYCLES(4)) dut (.Clock(Clock), .Reset(Reset), .hz(hz.slave));
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  wire [7:0] ctl = {hz.PCWrite, hz.IFID_WriteEnable, hz.IFID_Flush, hz.IDEX_Bubble,
                    hz.EXMEM_Bubble, hz.StageWriteEnable};
  localparam logic [7:0] NORMAL  = 8'b11_0_0_0_111;
  localparam logic [7:0] STALL   = 8'b00_0_1_0_111;
  localparam logic [7:0] FLUSH   = 8'b11_1_0_0_111;
  localparam logic [7:0] FREEZE  = 8'b00_0_0_1_110;
  localparam logic [7:0] RESET_O = 8'b00_1_1_1_000;
`ifdef HAZARD_MUL_STALL_EN
  localparam bit MUL_EN = 1'b1;
  localparam logic [7:0] MUL_EXP = FREEZE;
  localparam logic [15:0] MUL_STALLS = 16'd3;
`else
  localparam bit MUL_EN = 1'b0;
  localparam logic [7:0] MUL_EXP = NORMAL;
  localparam logic [15:0] MUL_STALLS = 16'd0;
`endif
  localparam logic [5:0] OPS [13] = '{6'b000000, 6'b000010, 6'b000011, 6'b001111, 6'b000100,
                                      6'b000101, 6'b011100, 6'b011111, 6'b100011, 6'b101000,
                                      6'b101001, 6'b101011, 6'b001000};

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input int op, rs, rt, br, jmp, tk, imr, irw, iwr, mul, emr, ewr);
    hz.IFID_OpCode = 6'(op);
    hz.IFID_Rs = 5'(rs);
    hz.IFID_Rt = 5'(rt);
    hz.ID_Branch = 1'(br);
    hz.ID_Jump = 1'(jmp);
    hz.ID_BranchTaken = 1'(tk);
    hz.IDEX_MemRead = 1'(imr);
    hz.IDEX_RegWrite = 1'(irw);
    hz.IDEX_WriteReg = 5'(iwr);
    hz.IDEX_Mul = 1'(mul);
    hz.EXMEM_MemRead = 1'(emr);
    hz.EXMEM_WriteReg = 5'(ewr);
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    drive(0, 2, 4, 1, 1, 1, 1, 1, 2, 1, 1, 2);
    #1;
    checks++;
    if (ctl !== RESET_O) begin failures++; $display("FAIL reset_outputs ctl=%b expected=%b", ctl, RESET_O); end
    tick();
    checks++;
    if (hz.StallCount !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d expected=0", hz.StallCount); end
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL post_reset ctl=%b expected=%b", ctl, NORMAL); end
  endtask

  task automatic test_load_use;
    do_reset();
    drive(0, 2, 4, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== STALL) begin failures++; $display("FAIL load_use_stall ctl=%b expected=%b", ctl, STALL); end
    tick();
    drive(0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL load_use_release ctl=%b expected=%b", ctl, NORMAL); end
    checks++;
    if (hz.StallCount !== 16'd1) begin failures++; $display("FAIL load_use_count got=%0d expected=1", hz.StallCount); end
  endtask

  task automatic test_source_use;
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL reg_zero ctl=%b expected=%b", ctl, NORMAL); end
    drive(6'b001111, 2, 7, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL lui_no_rs ctl=%b expected=%b", ctl, NORMAL); end
    drive(6'b001000, 1, 2, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL addi_no_rt ctl=%b expected=%b", ctl, NORMAL); end
    drive(6'b101011, 1, 2, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== STALL) begin failures++; $display("FAIL sw_rt_use ctl=%b expected=%b", ctl, STALL); end
  endtask

  task automatic test_load_branch;
    do_reset();
    drive(6'b000100, 5, 0, 1, 0, 1, 1, 1, 5, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== STALL) begin failures++; $display("FAIL ld_br_stall1 ctl=%b expected=%b", ctl, STALL); end
    tick();
    drive(6'b000100, 5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 5);
    #1;
    checks++;
    if (ctl !== STALL) begin failures++; $display("FAIL ld_br_stall2 ctl=%b expected=%b", ctl, STALL); end
    tick();
    drive(6'b000100, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== FLUSH) begin failures++; $display("FAIL ld_br_flush ctl=%b expected=%b", ctl, FLUSH); end
    checks++;
    if (hz.StallCount !== 16'd2) begin failures++; $display("FAIL ld_br_count got=%0d expected=2", hz.StallCount); end
    tick();
    drive(6'b000101, 0, 6, 1, 0, 0, 0, 1, 6, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== STALL) begin failures++; $display("FAIL alu_br_stall ctl=%b expected=%b", ctl, STALL); end
    tick();
    drive(6'b000101, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 6);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL alu_br_release ctl=%b expected=%b", ctl, NORMAL); end
    checks++;
    if (hz.StallCount !== 16'd3) begin failures++; $display("FAIL alu_br_count got=%0d expected=3", hz.StallCount); end
  endtask

  task automatic test_jump;
    do_reset();
    drive(6'b000010, 5, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== FLUSH) begin failures++; $display("FAIL jump_flush ctl=%b expected=%b", ctl, FLUSH); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL jump_after ctl=%b expected=%b", ctl, NORMAL); end
    checks++;
    if (hz.StallCount !== 16'd0) begin failures++; $display("FAIL jump_count got=%0d expected=0", hz.StallCount); end
  endtask

  task automatic test_mul;
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL mul_entry ctl=%b expected=%b", ctl, NORMAL); end
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(6'b000010, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      #1;
      checks++;
      if (ctl !== (MUL_EN ? FREEZE : FLUSH)) begin
        failures++;
        $display("FAIL mul_freeze%0d ctl=%b expected=%b", i, ctl, MUL_EN ? FREEZE : FLUSH);
      end
    end
    tick();
    #1;
    checks++;
    if (ctl !== FLUSH) begin failures++; $display("FAIL mul_ack_cycle ctl=%b expected=%b", ctl, FLUSH); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL mul_done ctl=%b expected=%b", ctl, NORMAL); end
    checks++;
    if (hz.StallCount !== MUL_STALLS) begin
      failures++;
      $display("FAIL mul_count got=%0d expected=%0d", hz.StallCount, MUL_STALLS);
    end
  endtask

  task automatic test_reset_mid_mul;
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    #1;
    checks++;
    if (ctl !== MUL_EXP) begin failures++; $display("FAIL mid_mul_first ctl=%b expected=%b", ctl, MUL_EXP); end
    tick();
    Reset = 1'b1;
    #1;
    checks++;
    if (ctl !== RESET_O) begin failures++; $display("FAIL mid_mul_reset ctl=%b expected=%b", ctl, RESET_O); end
    tick();
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL mid_mul_after ctl=%b expected=%b", ctl, NORMAL); end
    checks++;
    if (hz.StallCount !== 16'd0) begin failures++; $display("FAIL mid_mul_count got=%0d expected=0", hz.StallCount); end
    tick();
    #1;
    checks++;
    if (ctl !== NORMAL) begin failures++; $display("FAIL mid_mul_settled ctl=%b expected=%b", ctl, NORMAL); end
  endtask

  function automatic bit reads(input logic [5:0] op, input logic [4:0] r, input bit rt_field);
    if (r == 5'd0) return 1'b0;
    if (rt_field) return op inside {6'b000000, 6'b000100, 6'b000101, 6'b011100,
                                    6'b011111, 6'b101000, 6'b101001, 6'b101011};
    return !(op inside {6'b000010, 6'b000011, 6'b001111});
  endfunction

  task automatic test_random;
    int freeze_left = 0;
    bit ack = 1'b0;
    int stalls = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      logic [4:0] rs, rt, iwr, ewr;
      bit br, jmp, tk, imr, irw, mul, emr, dep_ex, dep_mem, hazard, redirect, starting;
      logic [7:0] exp_ctl;
      op = OPS[$urandom_range(12)];
      rs = 5'($urandom_range(3));
      rt = 5'($urandom_range(3));
      iwr = 5'($urandom_range(3));
      ewr = 5'($urandom_range(3));
      br = 1'($urandom_range(1));
      jmp = ($urandom_range(3) == 0);
      tk = 1'($urandom_range(1));
      imr = 1'($urandom_range(1));
      irw = 1'($urandom_range(1));
      mul = ($urandom_range(7) == 0);
      emr = 1'($urandom_range(1));
      drive(op, rs, rt, br, jmp, tk, imr, irw, iwr, mul, emr, ewr);
      dep_ex = (reads(op, rs, 1'b0) && rs == iwr) || (reads(op, rt, 1'b1) && rt == iwr);
      dep_mem = (reads(op, rs, 1'b0) && rs == ewr) || (reads(op, rt, 1'b1) && rt == ewr);
      hazard = (imr && dep_ex) || (br && ((irw && dep_ex) || (emr && dep_mem)));
      redirect = jmp || (br && tk);
      starting = MUL_EN && mul && !ack && freeze_left == 0;
      exp_ctl = freeze_left > 0 ? FREEZE : starting ? NORMAL : hazard ? STALL : redirect ? FLUSH : NORMAL;
      #1;
      checks++;
      if (ctl !== exp_ctl) begin failures++; $display("FAIL random_ctl cycle=%0d ctl=%b expected=%b", n, ctl, exp_ctl); end
      checks++;
      if (hz.StallCount !== 16'(stalls)) begin
        failures++;
        $display("FAIL random_count cycle=%0d got=%0d expected=%0d", n, hz.StallCount, stalls);
      end
      tick();
      if (!exp_ctl[7] && stalls < 65535) stalls++;
      if (freeze_left > 0) begin
        freeze_left--;
        ack = (freeze_left == 0);
      end else begin
        ack = 1'b0;
        if (starting) freeze_left = 3;
      end
    end
  endtask

  task automatic test_saturation;
    do_reset();
    drive(0, 2, 4, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    repeat (65534) tick();
    checks++;
    if (hz.StallCount !== 16'hFFFE) begin failures++; $display("FAIL sat_before got=%h expected=fffe", hz.StallCount); end
    repeat (6) tick();
    checks++;
    if (hz.StallCount !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h expected=ffff", hz.StallCount); end
    checks++;
    if (ctl !== STALL) begin failures++; $display("FAIL sat_ctl ctl=%b expected=%b", ctl, STALL); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_source_use();
    test_load_branch();
    test_jump();
    test_mul();
    test_reset_mid_mul();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
